// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and fetch sequencer between Control_Unit and the instruction RAM
module instr_fetch_unit #(
    parameter int IR_width = 12,
    parameter int PC_width = 8,
    parameter int MEM_LAT  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                halt,
    input  logic [1:0]          mem_read,
    input  logic                PC_Inc,
    input  logic                pc_load,
    input  logic [PC_width-1:0] pc_load_val,
    input  logic [IR_width-1:0] mem_rdata,
    output logic                mem_rd_en,
    output logic [PC_width-1:0] mem_addr,
    output logic [PC_width-1:0] pc,
    output logic [IR_width-1:0] opcode,
    output logic [IR_width-1:0] operand,
    output logic                ir_valid,
    output logic                op_valid,
    output logic                busy,
    output logic                err
);
    localparam logic [2:0] IDLE = 3'd0, READY = 3'd1, ISSUE = 3'd2, WAIT = 3'd3, CAPTURE = 3'd4;
    logic [2:0] state, state_n;
    logic [1:0] wcnt;
    logic tgt_op, halt_pend, req, accept;
    // CAPTURE doubles as an accept slot so back-to-back fetches lose no cycle
    always_comb begin
        req = mem_read == 2'b01 || mem_read == 2'b10;
        accept = req && (state == READY || state == CAPTURE);
        busy = state == ISSUE || state == WAIT || state == CAPTURE;
        state_n = state == IDLE  ? (start ? READY : IDLE) :
                  state == READY ? (accept ? ISSUE : (halt || halt_pend) && mem_read == 2'b00 ? IDLE : READY) :
                  state == ISSUE ? (MEM_LAT > 1 ? WAIT : CAPTURE) :
                  state == WAIT  ? (wcnt == 2'(MEM_LAT - 2) ? CAPTURE : WAIT) :
                  accept ? ISSUE : READY;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wcnt <= '0;
            tgt_op <= 1'b0;
            halt_pend <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr <= '0;
            pc <= '0;
            opcode <= '0;
            operand <= '0;
            ir_valid <= 1'b0;
            op_valid <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            wcnt <= state == WAIT ? wcnt + 2'd1 : 2'd0;
            halt_pend <= state_n != IDLE && (halt_pend || (halt && busy));
            mem_rd_en <= accept;
            err <= err || mem_read == 2'b11 || (req && !accept);
            if (state != IDLE)
                pc <= pc_load ? pc_load_val : PC_Inc ? pc + PC_width'(1) : pc;
            if (state == CAPTURE) begin
                if (tgt_op) begin
                    operand <= mem_rdata;
                    op_valid <= 1'b1;
                end else begin
                    opcode <= mem_rdata;
                    ir_valid <= 1'b1;
                end
            end
            // a new fetch accepted on the capture edge invalidates its own target
            if (accept) begin
                mem_addr <= pc;
                tgt_op <= mem_read[1];
                if (mem_read[1])
                    op_valid <= 1'b0;
                else
                    ir_valid <= 1'b0;
            end
        end
    end
endmodule
